led_pattern_gen: RTL and testbench

Parametrised multi-channel LED driver, the successor to the single hard-wired LED output. Each of NUM_LEDS channels is independently configured over a simple write port into one of four modes: OFF, ON, BLINK, PWM. A shared prescaler and a shared PWM counter time all channels. The block sits between the top-level user pins and the output pads (uo_out/uio_out).

---
 rtl/led_pattern_gen.sv | 137 +++++++++++++
 tb/tb_led_pattern_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator. Each channel runs in OFF, ON, BLINK
// or PWM mode and is configured through a single-cycle write port. One
// prescaler (blink timebase) and one free-running PWM counter are shared by
// all channels. The LED outputs are registered.
module led_pattern_gen #(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_addr,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_value,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick,
  output logic                pwm_wrap
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  localparam int                  PS_W   = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]     PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);

  logic [PS_W-1:0]     presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] raw;

  // Prescaler counts 0..PRESCALE-1; tick pulses in the cycle after the top count.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      tick      <= (presc_cnt == PS_MAX);
      presc_cnt <= (presc_cnt == PS_MAX) ? '0 : presc_cnt + 1'b1;
    end
  end

  // Free-running PWM counter, wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_wrap = &pwm_cnt;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    mode_e               mode_q;
    mode_e               new_mode;
    logic [PWM_BITS-1:0] shadow_q;
    logic [PWM_BITS-1:0] active_q;
    logic [PWM_BITS-1:0] blink_cnt_q;
    logic                phase_q;
    logic                wr_hit;
    logic                mode_change;
    logic                blink_done;
    logic                ch_raw;

    // Addresses at or above NUM_LEDS match no channel, so such writes vanish.
    assign wr_hit      = cfg_we && (cfg_addr == 3'(i));
    assign new_mode    = mode_e'(cfg_mode);
    assign mode_change = (new_mode != mode_q);
    // Only consulted while active_q != 0, so active_q - 1 cannot underflow.
    assign blink_done  = (blink_cnt_q >= active_q - ONE);

    // Channel configuration, active value reload and blink timing.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q      <= MODE_OFF;
        shadow_q    <= '0;
        active_q    <= '0;
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else begin
        if (wr_hit) begin
          mode_q   <= new_mode;
          shadow_q <= cfg_value;
        end

        // Same-mode PWM writes wait for the wrap so a period is never cut short;
        // a write landing on the wrap edge itself loads the previous shadow.
        if (wr_hit && (mode_change || new_mode != MODE_PWM))
          active_q <= cfg_value;
        else if (mode_q == MODE_PWM && pwm_wrap)
          active_q <= shadow_q;

        // Any write into BLINK restarts the pattern with the LED lit.
        if (wr_hit && new_mode == MODE_BLINK) begin
          blink_cnt_q <= '0;
          phase_q     <= 1'b1;
        end else if (mode_q == MODE_BLINK && tick && active_q != '0) begin
          if (blink_done) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
        end
      end
    end

    // Raw (pre-enable, pre-polarity) channel level.
    // NOTE: the output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      ch_raw = 1'b0;
      unique case (mode_q)
        MODE_OFF:   ch_raw = 1'b0;
        MODE_ON:    ch_raw = 1'b1;
        MODE_BLINK: ch_raw = phase_q && (active_q != '0);
        MODE_PWM:   ch_raw = (pwm_cnt < active_q);
        default:    ch_raw = 1'b0;
      endcase
    end

    assign raw[i] = ch_raw;
  end

  // Registered pin drive: enable gating then polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= {NUM_LEDS{ACTIVE_LOW}};
    else     led <= ({NUM_LEDS{en}} & raw) ^ {NUM_LEDS{ACTIVE_LOW}};
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with 4 channels, 4-bit PWM and a
// prescale of 4. A second instance with inverted outputs shares all inputs.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int PB = 4;
  localparam int PS = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [1:0]    cfg_mode;
  logic [PB-1:0] cfg_value;
  logic [N-1:0]  led;
  logic [N-1:0]  led_al;
  logic          tick;
  logic          tick_al;
  logic          pwm_wrap;
  logic          pwm_wrap_al;

  int checks   = 0;
  int failures = 0;

  led_pattern_gen #(.NUM_LEDS(N), .PWM_BITS(PB), .PRESCALE(PS), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .led(led), .tick(tick),
    .pwm_wrap(pwm_wrap)
  );

  led_pattern_gen #(.NUM_LEDS(N), .PWM_BITS(PB), .PRESCALE(PS), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .led(led_al), .tick(tick_al),
    .pwm_wrap(pwm_wrap_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [1:0] m, input logic [PB-1:0] v);
    cfg_addr  = a;
    cfg_mode  = m;
    cfg_value = v;
    cfg_we    = 1'b1;
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic sync_wrap();
    int n = 0;
    while (pwm_wrap !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check("sync_wrap", 32'(pwm_wrap), 32'd1);
  endtask

  task automatic sync_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check("sync_tick", 32'(tick), 32'd1);
  endtask

  function automatic int ones(input logic [60:1] v, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(v[k]);
    return c;
  endfunction

  initial begin
    int            hi_a;
    int            hi_b;
    logic [60:1]   bl;
    logic [N-1:0]  exp_led;
    logic          en_seen;

    rst = 1'b0; en = 1'b1; cfg_we = 1'b0;
    cfg_addr = '0; cfg_mode = '0; cfg_value = '0;
    #2 rst = 1'b1;
    step(3);

    // Reset state.
    check("rst_led", 32'(led), 32'h0);
    check("rst_led_al", 32'(led_al), 32'hF);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_tick_al", 32'(tick_al), 32'h0);
    check("rst_wrap", 32'(pwm_wrap), 32'h0);
    check("rst_wrap_al", 32'(pwm_wrap_al), 32'h0);

    // Release: first tick after 4 edges, first wrap after 15.
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      if (k <= 5)  check($sformatf("tick_k%0d", k), 32'(tick), 32'(k == 4));
      if (k >= 14) check($sformatf("wrap_k%0d", k), 32'(pwm_wrap), 32'(k == 15));
    end

    // ON, two-edge latency, invalid addresses, enable gating.
    cfg_write(3'd2, 2'd1, '0);
    check("on_latency", 32'(led), 32'h0);
    step(1);
    check("on_led", 32'(led), 32'h4);
    check("on_led_al", 32'(led_al), 32'hB);
    cfg_write(3'd5, 2'd1, '0);
    cfg_write(3'd4, 2'd3, 4'd9);
    step(1);
    check("bad_addr", 32'(led), 32'h4);
    en = 1'b0;
    step(1);
    check("en_off", 32'(led), 32'h0);
    check("en_off_al", 32'(led_al), 32'hF);
    en = 1'b1;
    step(1);
    check("en_on", 32'(led), 32'h4);
    cfg_write(3'd2, 2'd0, '0);
    step(1);
    check("off_led", 32'(led), 32'h0);

    // PWM duty over one full 16-cycle window.
    cfg_write(3'd0, 2'd3, 4'd4);
    step(2);
    hi_a = 0;
    repeat (16) begin hi_a += int'(led[0]); step(1); end
    check("pwm_duty4", 32'(hi_a), 32'd4);

    cfg_write(3'd0, 2'd3, 4'd0);
    step(18);
    hi_a = 0;
    repeat (16) begin hi_a += int'(led[0]); step(1); end
    check("pwm_duty0", 32'(hi_a), 32'd0);

    cfg_write(3'd0, 2'd3, 4'd15);
    step(18);
    hi_a = 0;
    repeat (16) begin hi_a += int'(led[0]); step(1); end
    check("pwm_duty15", 32'(hi_a), 32'd15);

    cfg_write(3'd0, 2'd3, 4'd4);
    step(18);

    // Mid-period duty change: current period keeps 4, next shows 12.
    sync_wrap();
    cfg_addr = 3'd0; cfg_mode = 2'd3; cfg_value = 4'd12;
    hi_a = 0; hi_b = 0;
    for (int i = 1; i <= 33; i++) begin
      step(1);
      cfg_we = (i == 4);
      if (i >= 2 && i <= 17) hi_a += int'(led[0]);
      else if (i >= 18)      hi_b += int'(led[0]);
    end
    check("glitch_cur", 32'(hi_a), 32'd4);
    check("glitch_next", 32'(hi_b), 32'd12);

    // Write on the wrap cycle: old shadow loads now, new duty a period later.
    sync_wrap();
    cfg_value = 4'd2;
    cfg_we    = 1'b1;
    hi_a = 0; hi_b = 0;
    for (int i = 1; i <= 33; i++) begin
      step(1);
      if (i == 1) cfg_we = 1'b0;
      if (i >= 2 && i <= 17) hi_a += int'(led[0]);
      else if (i >= 18)      hi_b += int'(led[0]);
    end
    check("wrapwr_cur", 32'(hi_a), 32'd12);
    check("wrapwr_next", 32'(hi_b), 32'd2);

    // BLINK value 3 started on a tick edge, then rewritten to 1 mid-low.
    cfg_write(3'd0, 2'd0, '0);
    sync_tick();
    cfg_addr = 3'd1; cfg_mode = 2'd2; cfg_value = 4'd3;
    cfg_we   = 1'b1;
    bl = '0;
    for (int i = 1; i <= 60; i++) begin
      step(1);
      if (i == 1)  cfg_we = 1'b0;
      if (i == 41) begin cfg_value = 4'd1; cfg_we = 1'b1; end
      if (i == 42) cfg_we = 1'b0;
      bl[i] = led[1];
    end
    check("blink_hi1", 32'(ones(bl, 2, 13)), 32'd12);
    check("blink_lo1", 32'(ones(bl, 14, 25)), 32'd0);
    check("blink_hi2", 32'(ones(bl, 26, 37)), 32'd12);
    check("blink_lo2", 32'(ones(bl, 38, 42)), 32'd0);
    check("rewrite_lit", 32'(bl[43]), 32'd1);
    check("rewrite_hi_a", 32'(ones(bl, 43, 45)), 32'd3);
    check("rewrite_lo_a", 32'(ones(bl, 46, 49)), 32'd0);
    check("rewrite_hi_b", 32'(ones(bl, 50, 53)), 32'd4);
    check("rewrite_lo_b", 32'(ones(bl, 54, 57)), 32'd0);

    // All together: ch0 PWM 4, ch1 BLINK 1, ch3 ON, en off for 20 cycles.
    cfg_write(3'd3, 2'd1, '0);
    cfg_write(3'd0, 2'd3, 4'd4);
    sync_wrap();
    cfg_addr = 3'd1; cfg_mode = 2'd2; cfg_value = 4'd1;
    cfg_we   = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      step(1);
      if (j == 1)  cfg_we = 1'b0;
      if (j == 29) en = 1'b0;
      if (j == 49) en = 1'b1;
      if (j >= 3) begin
        en_seen = !(j >= 30 && j <= 49);
        exp_led = {1'b1, 1'b0, (((j - 3) / 4) % 2) == 1, ((j - 2) % 16) < 4};
        if (!en_seen) exp_led = '0;
        check($sformatf("multi_j%0d", j), 32'(led), 32'(exp_led));
      end
    end

    // Asynchronous reset mid-pattern, then restart timing.
    #3 rst = 1'b1;
    #1;
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_led_al", 32'(led_al), 32'hF);
    check("midrst_tick", 32'(tick), 32'h0);
    check("midrst_wrap", 32'(pwm_wrap), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check($sformatf("midrst_tick_k%0d", k), 32'(tick), 32'(k == 4));
    end
    check("midrst_modes_off", 32'(led), 32'h0);
    check("midrst_modes_off_al", 32'(led_al), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
